// File: rtl/taint_pkg.sv
// Shared constants, slot state type and the tag-propagation function for the taint arbiter.
package taint_pkg;

  localparam int PAIR_W = 64;
  localparam int HALF_W = 32;
  localparam int TAG_HI = 63;
  localparam int TAG_LO = 31;

  typedef enum logic {EMPTY, FULL} slot_state_t;

  // Either tag set taints both halves; payload bits are untouched.
  function automatic logic [PAIR_W-1:0] taint_prop(input logic [PAIR_W-1:0] pair);
    logic t;
    t = pair[TAG_HI] | pair[TAG_LO];
    return {t, pair[TAG_HI-1:HALF_W], t, pair[TAG_LO-1:0]};
  endfunction

endpackage

// File: rtl/taint_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant from the pointer, pointer moves past the winner on advance.
// No backpressure of its own; the caller qualifies the grant and drives advance.
module taint_rr_arb #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      idx
);

  logic [1:0]      ptr_q, ptr_d;
  logic [NREQ-1:0] elig;
  logic            found;
  int              pos;

  assign elig = req & mask;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int i = 0; i < NREQ; i++) begin
      pos = int'(ptr_q) + i;
      if (pos >= NREQ) pos = pos - NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!found && elig[j] && (j == pos)) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          idx    = 2'(j);
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      if (int'(idx) == NREQ - 1) ptr_d = '0;
      else                       ptr_d = idx + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/taint_arbiter.sv
// Round-robin share of one taint stage; result registered 1 cycle after grant, grants only into an empty or draining slot.
// Optional TAINT_LOCK_EN: after a tainted accept, only requester 0 is served until lock_clr.
module taint_arbiter
  import taint_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [PAIR_W*NREQ-1:0] req_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [PAIR_W-1:0]      rsp_data,
  output logic [1:0]             rsp_id,
  output logic                   rsp_tainted,
  input  logic                   cnt_clr,
  output logic [CNT_W-1:0]       taint_cnt
`ifdef TAINT_LOCK_EN
  ,
  input  logic                   lock_clr,
  output logic                   locked
`endif
);

  slot_state_t       state_q, state_d;
  logic [PAIR_W-1:0] rsp_data_q, pair_sel, pair_prop;
  logic [1:0]        rsp_id_q, gnt_idx;
  logic              rsp_tainted_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt, mask;
  logic              grant_en, grant, accept_taint;

  assign grant_en     = (state_q == EMPTY) || rsp_ready;
  assign grant        = grant_en && (|gnt);
  assign req_ready    = grant_en ? gnt : '0;
  assign accept_taint = (state_q == FULL) && rsp_ready && rsp_tainted_q;

`ifdef TAINT_LOCK_EN
  logic locked_q;

  assign mask   = locked_q ? NREQ'(1) : '1;
  assign locked = locked_q;

  // A fresh tainted accept outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               locked_q <= 1'b0;
    else if (accept_taint) locked_q <= 1'b1;
    else if (lock_clr)     locked_q <= 1'b0;
  end
`else
  assign mask = '1;
`endif

  taint_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .mask    (mask),
    .advance (grant),
    .gnt     (gnt),
    .idx     (gnt_idx)
  );

  assign pair_sel  = req_data[int'(gnt_idx)*PAIR_W +: PAIR_W];
  assign pair_prop = taint_prop(pair_sel);

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (grant) state_d = FULL;
      FULL:    if (rsp_ready && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)                         cnt_d = accept_taint ? CNT_W'(1) : '0;
    else if (accept_taint && ~&cnt_q)    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= EMPTY;
      rsp_data_q    <= '0;
      rsp_id_q      <= '0;
      rsp_tainted_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        rsp_data_q    <= pair_prop;
        rsp_id_q      <= gnt_idx;
        rsp_tainted_q <= pair_prop[TAG_HI];
      end
    end
  end

  assign rsp_valid   = (state_q == FULL);
  assign rsp_data    = rsp_data_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_tainted = rsp_tainted_q;
  assign taint_cnt   = cnt_q;

endmodule

// File: doc/taint_arbiter.md
Name: taint_arbiter

Overview:
- Shares a single taint-propagation stage between NREQ requesters, each submitting a 64-bit tagged pair.
- Tagged pair layout: two 32-bit halves; bit 63 is the upper-half taint tag, bit 31 is the lower-half taint tag.
- The stage ORs the two tags into both tag positions.
- Sits between the execute/memory requesters and the writeback path: round-robin grant, one registered result slot, valid/ready handshakes, saturating taint-event counter.

Parameters:
- NREQ, 2, number of requesters (legal 2..4).
- CNT_W, 16, width of the taint-event counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_data  in  64*NREQ  tagged pairs; requester k occupies bits [64k+63:64k].
- rsp_valid  out  1  result slot holds a valid result.
- rsp_ready  in  1  downstream accepts the result.
- rsp_data  out  64  propagated tagged pair.
- rsp_id  out  2  index of the requester that produced rsp_data.
- rsp_tainted  out  1  either input tag was set.
- cnt_clr  in  1  synchronous clear of taint_cnt.
- taint_cnt  out  CNT_W  number of tainted results accepted downstream, saturating.

Behaviour:
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_tainted=0, taint_cnt=0, round-robin pointer=0 (requester 0 has highest priority first). An asserted rst mid-transfer drops the held result without delivering it.
- Slot FSM:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY when rsp_ready and there is no grant.
  - FULL -> FULL when rsp_ready with a grant (back-to-back, throughput 1 per cycle).
  - FULL holds all rsp_* stable while rsp_ready=0.
- Grant condition: slot EMPTY, or (FULL and rsp_ready). req_ready is combinational from req_valid, the pointer and slot state. A requester must not depend on req_ready to drive req_valid.
- Arbitration:
  - Round-robin over the asserted req_valid bits, starting at the pointer.
  - After a grant to k, pointer = (k+1) mod NREQ.
  - Pointer is unchanged when there is no grant.
  - A request that is not granted stays pending; req_data must remain stable until granted.
- Propagation, latency 1 cycle from grant to rsp_valid:
  - t = d[63] | d[31].
  - rsp_data = {t, d[62:32], t, d[30:0]}.
  - rsp_tainted = t.
  - Untagged data passes through bit-exact.
- taint_cnt:
  - Increments on a cycle with rsp_valid & rsp_ready & rsp_tainted.
  - Saturates at all-ones; no wrap.
  - cnt_clr in the same cycle as an increment gives taint_cnt=1.
  - cnt_clr alone gives 0.
- rsp_id width is fixed at 2 bits; upper bits are 0 when NREQ=2.

Optional Feature:
- Macro: TAINT_LOCK_EN.
- Enabled:
  - Adds ports lock_clr (in, 1) and locked (out, 1, reset 0).
  - locked sets on the cycle after a tainted result is accepted downstream; lock_clr clears it, and set wins on a tie.
  - While locked, grants to requesters 1..NREQ-1 are masked; only requester 0 (trusted) is served.
  - The pointer skips masked requesters.
- Disabled: the ports are absent and no masking occurs.

Decomposition:
- Package taint_pkg holds:
  - constants TAG_HI=63, TAG_LO=31, PAIR_W=64, HALF_W=32;
  - function taint_prop(pair) returning the propagated pair;
  - typedef slot_state_t {EMPTY, FULL}.
- Sub-module taint_rr_arb (NREQ-wide round-robin): inputs req, mask, advance; outputs one-hot gnt and encoded index.
- The datapath is inline in taint_arbiter.

Test Plan:
- Single requester 0, clean data: req_data=64'h70042331700FACE0 -> rsp_data=64'h70042331700FACE0, rsp_tainted=0, rsp_id=0, one cycle after grant; taint_cnt stays 0.
- Lower-tag taint: req 1 sends 64'h700000008CAEF120 -> rsp_data=64'hF00000008CAEF120, rsp_tainted=1. Upper-tag taint: req 0 sends 64'h8000000000000000 -> rsp_data=64'h8000000080000000. taint_cnt=2 after both are accepted.
- Both requesters valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1; one result per cycle; rsp_id alternates.
- Backpressure: rsp_ready=0 for 5 cycles with the slot FULL -> rsp_data and rsp_id stable, req_ready=0; on release, the next grant goes to the pointer's requester in the same cycle.
- Counter edges: preload to 16'hFFFF via tainted traffic -> stays 16'hFFFF. cnt_clr together with a tainted accept -> 1. rst asserted mid-FULL -> rsp_valid=0 immediately (asynchronous).
- With TAINT_LOCK_EN: tainted accept from req 1 -> locked=1; req 1 is then never granted while req 0 is served. lock_clr -> req 1 is granted again.
